// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Widest pattern the sweeper supports; gray() works on this width.
  localparam int GRAY_W = 8;

  function automatic int n_pat(input int n_in);
    return 1 << n_in;
  endfunction

  // Counter width able to hold 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [GRAY_W-1:0] gray(input logic [GRAY_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// Counts the clocks a pattern has been held; flags the last hold cycle.
module tt_hold_timer
  import tt_pkg::*;
#(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int W = cnt_w(HOLD);
  localparam logic [W-1:0] LAST = W'(HOLD - 1);

  logic [W-1:0] hold_q, hold_d;

  assign last_o = (hold_q == LAST);

  always_comb begin
    hold_d = hold_q;
    if (clr_i || (en_i && last_o)) hold_d = '0;
    else if (en_i)                 hold_d = hold_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

endmodule

// File: rtl/tt_sweeper.sv
// Exhaustive truth-table sweeper: drives every N_IN-bit pattern for HOLD clocks
// and captures the DUT response into table_out. Define SWEEP_GRAY_EN for Gray order.
module tt_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int HOLD  = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_OUT-1:0]            dut_resp,
  output logic [N_IN-1:0]             pat_out,
  output logic                        busy,
  output logic                        sample,
  output logic                        done,
  output logic [N_OUT*(2**N_IN)-1:0]  table_out
);

  localparam int N_PAT = n_pat(N_IN);
  localparam int TBL_W = N_OUT * N_PAT;
  localparam logic [N_IN-1:0] LAST_STEP = N_IN'(N_PAT - 1);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   step_q, step_d;
  logic [TBL_W-1:0]  table_q, table_d;
  logic              run, last, accept;

  assign run    = (state_q == RUN);
  assign accept = (state_q == IDLE) && start;

  tt_hold_timer #(.HOLD(HOLD)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (run),
    .last_o (last)
  );

`ifdef SWEEP_GRAY_EN
  assign pat_out = N_IN'(gray(GRAY_W'(step_q)));
`else
  assign pat_out = step_q;
`endif

  assign busy      = run;
  assign sample    = run && last;
  assign done      = (state_q == FIN);
  assign table_out = table_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    table_d = table_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          step_d  = '0;
          table_d = '0;
        end
      end
      RUN: begin
        if (last) begin
          // Row is addressed by the pattern value, so Gray order lands in the same slots.
          table_d[int'(pat_out)*N_OUT +: N_OUT] = dut_resp;
          if (step_q == LAST_STEP) begin
            state_d = FIN;
            step_d  = '0;
          end else begin
            step_d  = step_q + 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      table_q <= table_d;
    end
  end

endmodule

// File: tb/tb_tt_sweeper.sv
// Bench for tt_sweeper: majority-gate sweep (N_IN=3, HOLD=10) and half-adder sweep (N_IN=2, N_OUT=2, HOLD=2).
module tb_tt_sweeper;

  localparam int HA = 10;
  localparam int HB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       resp_a;
  logic [1:0] resp_b;
  logic [2:0] pat_a;
  logic [1:0] pat_b;
  logic       busy_a, sample_a, done_a;
  logic       busy_b, sample_b, done_b;
  logic [7:0] tbl_a, tbl_b;

  always #5 clk = ~clk;

  assign resp_a = (pat_a[2] & pat_a[1]) | (pat_a[2] & pat_a[0]) | (pat_a[1] & pat_a[0]);
  assign resp_b = {pat_b[1] & pat_b[0], pat_b[1] ^ pat_b[0]};

  tt_sweeper #(.N_IN(3), .N_OUT(1), .HOLD(HA)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_resp(resp_a), .pat_out(pat_a),
    .busy(busy_a), .sample(sample_a), .done(done_a), .table_out(tbl_a)
  );

  tt_sweeper #(.N_IN(2), .N_OUT(2), .HOLD(HB)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_resp(resp_b), .pat_out(pat_b),
    .busy(busy_b), .sample(sample_b), .done(done_b), .table_out(tbl_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { int pat; int cyc; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  function automatic int order(input int k);
`ifdef SWEEP_GRAY_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  // Monitors: count busy/done, pop the scoreboard on every sample.
  int busy_cnt_a = 0, done_cnt_a = 0, done_cyc_a = -1;
  int busy_cnt_b = 0, done_cnt_b = 0, done_cyc_b = -1;
  logic busy_pa = 1'b0, samp_pa = 1'b0, busy_pb = 1'b0, samp_pb = 1'b0;
  logic [2:0] pat_pa = '0;
  logic [1:0] pat_pb = '0;

  always @(negedge clk) begin
    exp_t e;
    if (busy_a) busy_cnt_a++;
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (busy_a && busy_pa && !samp_pa) chk("a_pat_stable", 64'(pat_a), 64'(pat_pa));
    if (sample_a) begin
      if (q_a.size() == 0) chk("a_unexpected_sample", 64'd1, 64'd0);
      else begin
        e = q_a.pop_front();
        chk("a_pat", 64'(pat_a), 64'(e.pat));
        chk("a_sample_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
    busy_pa = busy_a; samp_pa = sample_a; pat_pa = pat_a;
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy_b) busy_cnt_b++;
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
    if (busy_b && busy_pb && !samp_pb) chk("b_pat_stable", 64'(pat_b), 64'(pat_pb));
    if (sample_b) begin
      if (q_b.size() == 0) chk("b_unexpected_sample", 64'd1, 64'd0);
      else begin
        e = q_b.pop_front();
        chk("b_pat", 64'(pat_b), 64'(e.pat));
        chk("b_sample_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
    busy_pb = busy_b; samp_pb = sample_b; pat_pb = pat_b;
  end

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic start_sweep_a(output int t);
    nclk();
    start_a = 1'b1;
    t = cyc + 1;
    for (int k = 0; k < 8; k++) q_a.push_back('{pat: order(k), cyc: t + (k + 1) * HA - 1});
    nclk();
    start_a = 1'b0;
  endtask

  // restart_at >= 0 re-pulses start during the sample cycle of that capture.
  task automatic sweep_a(input int restart_at);
    int t, n, b0, d0;
    b0 = busy_cnt_a;
    d0 = done_cnt_a;
    start_sweep_a(t);
    if (restart_at >= 0) begin
      n = 0;
      while (cyc < t + (restart_at + 1) * HA - 1 && n < 200) begin nclk(); n++; end
      chk("a_sample_at_restart", 64'(sample_a), 64'd1);
      start_a = 1'b1;
      nclk();
      start_a = 1'b0;
    end
    n = 0;
    while (done_cnt_a == d0 && n < 300) begin nclk(); n++; end
    if (n >= 300) chk("a_done_timeout", 64'd0, 64'd1);
    chk("a_done_cyc", 64'(done_cyc_a), 64'(t + 8 * HA));
    repeat (HA * 3) nclk();
    chk("a_busy_len", 64'(busy_cnt_a - b0), 64'(8 * HA));
    chk("a_done_pulses", 64'(done_cnt_a - d0), 64'd1);
    chk("a_table", 64'(tbl_a), 64'h00E8);
    chk("a_queue_empty", 64'(q_a.size()), 64'd0);
  endtask

  task automatic sweep_b();
    int t, n, b0, d0;
    b0 = busy_cnt_b;
    d0 = done_cnt_b;
    nclk();
    start_b = 1'b1;
    t = cyc + 1;
    for (int k = 0; k < 4; k++) q_b.push_back('{pat: order(k), cyc: t + (k + 1) * HB - 1});
    nclk();
    start_b = 1'b0;
    n = 0;
    while (done_cnt_b == d0 && n < 100) begin nclk(); n++; end
    if (n >= 100) chk("b_done_timeout", 64'd0, 64'd1);
    chk("b_done_cyc", 64'(done_cyc_b), 64'(t + 4 * HB));
    repeat (5) nclk();
    chk("b_busy_len", 64'(busy_cnt_b - b0), 64'(4 * HB));
    chk("b_done_pulses", 64'(done_cnt_b - d0), 64'd1);
    chk("b_table", 64'(tbl_b), 64'h0094);
    chk("b_queue_empty", 64'(q_b.size()), 64'd0);
  endtask

  initial begin
    int t, n, d0;
    rst = 1'b1;
    repeat (3) nclk();
    chk("rst_busy_a",   64'(busy_a),   64'd0);
    chk("rst_pat_a",    64'(pat_a),    64'd0);
    chk("rst_sample_a", 64'(sample_a), 64'd0);
    chk("rst_done_a",   64'(done_a),   64'd0);
    chk("rst_table_a",  64'(tbl_a),    64'd0);
    chk("rst_busy_b",   64'(busy_b),   64'd0);
    chk("rst_table_b",  64'(tbl_b),    64'd0);
    rst = 1'b0;

    // First sweep accepted at cycle 20.
    n = 0;
    while (cyc < 19 && n < 50) begin nclk(); n++; end
    sweep_a(-1);

    // Start during capture 3 must be ignored.
    sweep_a(3);

    // Reset 35 cycles into a sweep.
    d0 = done_cnt_a;
    start_sweep_a(t);
    n = 0;
    while (cyc < t + 35 && n < 100) begin nclk(); n++; end
    rst = 1'b1;
    nclk();
    chk("midrst_busy",  64'(busy_a), 64'd0);
    chk("midrst_pat",   64'(pat_a),  64'd0);
    chk("midrst_table", 64'(tbl_a),  64'd0);
    rst = 1'b0;
    q_a.delete();
    repeat (100) nclk();
    chk("midrst_no_done", 64'(done_cnt_a - d0), 64'd0);
    sweep_a(-1);

    sweep_b();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
